// File: rtl/player_state_ctrl_if.sv
// Player controller bus: frame strobe, environment/button inputs and
// the registered velocity / animation outputs.
interface player_state_ctrl_if #(
  parameter int VEL_W  = 8,
  parameter int STUN_W = 8
);
  logic                    tick;
  logic                    grounded;
  logic                    near_ledge;
  logic                    hit;
  logic [STUN_W-1:0]       hit_stun;
  logic signed [VEL_W-1:0] hit_kb_x;
  logic signed [VEL_W-1:0] hit_kb_y;
  logic                    btn_atk;
  logic                    btn_up;
  logic                    btn_down;
  logic                    btn_left;
  logic                    btn_right;
  logic                    btn_shield;
  logic signed [VEL_W-1:0] x_velocity;
  logic signed [VEL_W-1:0] y_velocity;
  logic [3:0]              current_animation;
  logic                    facing;

  modport master (
    output tick, grounded, near_ledge, hit, hit_stun, hit_kb_x, hit_kb_y,
           btn_atk, btn_up, btn_down, btn_left, btn_right, btn_shield,
    input  x_velocity, y_velocity, current_animation, facing
  );

  modport slave (
    input  tick, grounded, near_ledge, hit, hit_stun, hit_kb_x, hit_kb_y,
           btn_atk, btn_up, btn_down, btn_left, btn_right, btn_shield,
    output x_velocity, y_velocity, current_animation, facing
  );
endinterface

// File: rtl/player_state_ctrl.sv
// Per-player frame-stepped state controller. Chooses the player state on
// each frame tick, integrates velocity (gravity, jump, knockback) and
// produces a registered animation ID.
module player_state_ctrl #(
  parameter int VEL_W       = 8,
  parameter int STUN_W      = 8,
  parameter int WALK_SPD    = 3,
  parameter int JUMP_SPD    = 12,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 10,
  parameter int ATK_TICKS   = 20,
  parameter int DODGE_TICKS = 15,
  parameter int DODGE_SPD   = 6
) (
  input logic clk,
  input logic rst,
  player_state_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_MOVE, S_ATTACK, S_DODGE, S_SHIELD, S_LEDGE, S_HIT
  } state_t;

  localparam logic [3:0] A_IDLE   = 4'd0;
  localparam logic [3:0] A_WALK   = 4'd1;
  localparam logic [3:0] A_AIR    = 4'd2;
  localparam logic [3:0] A_ATTACK = 4'd3;
  localparam logic [3:0] A_DODGE  = 4'd4;
  localparam logic [3:0] A_SHIELD = 4'd5;
  localparam logic [3:0] A_LEDGE  = 4'd6;
  localparam logic [3:0] A_HIT    = 4'd7;

  localparam logic signed [VEL_W-1:0] JUMP_V  = VEL_W'(JUMP_SPD);
  localparam logic signed [VEL_W-1:0] WALK_V  = VEL_W'(WALK_SPD);
  localparam logic signed [VEL_W-1:0] DODGE_V = VEL_W'(DODGE_SPD);
  localparam int VEL_MIN = -(2 ** (VEL_W - 1));
  localparam int VEL_MAX = (2 ** (VEL_W - 1)) - 1;

  state_t                  state, state_n;
  logic [STUN_W-1:0]       timer, timer_n;
  logic signed [VEL_W-1:0] x_vel, x_vel_n, y_vel, y_vel_n;
  logic                    facing, facing_n;
  logic                    ledge_ok, ledge_ok_n;
  logic [3:0]              anim, anim_n;

  logic                    pend_valid;
  logic [STUN_W-1:0]       pend_stun;
  logic signed [VEL_W-1:0] pend_kb_x, pend_kb_y;

  logic prev_atk, prev_up, prev_lr;

  logic                    use_hit;
  logic [STUN_W-1:0]       eff_stun;
  logic signed [VEL_W-1:0] eff_kb_x, eff_kb_y;
  logic                    atk_rise, up_rise, lr_rise;

  // Gravity step, floored at -MAX_FALL and saturated to the velocity range
  function automatic logic signed [VEL_W-1:0] fall(input logic signed [VEL_W-1:0] v);
    int w;
    w = int'(v) - GRAVITY;
    if (w < -MAX_FALL) w = -MAX_FALL;
    if (w < VEL_MIN) w = VEL_MIN;
    if (w > VEL_MAX) w = VEL_MAX;
    return VEL_W'(w);
  endfunction

  // Next-state, velocity and animation selection for the coming tick
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    x_vel_n    = x_vel;
    y_vel_n    = y_vel;
    facing_n   = facing;
    ledge_ok_n = ledge_ok;
    anim_n     = anim;

    // A hit arriving on the tick cycle itself takes precedence over a pending one
    use_hit  = bus.hit | pend_valid;
    eff_stun = bus.hit ? bus.hit_stun : pend_stun;
    eff_kb_x = bus.hit ? bus.hit_kb_x : pend_kb_x;
    eff_kb_y = bus.hit ? bus.hit_kb_y : pend_kb_y;

    atk_rise = bus.btn_atk & ~prev_atk;
    up_rise  = bus.btn_up & ~prev_up;
    lr_rise  = (bus.btn_left ^ bus.btn_right) & ~prev_lr;

    if (use_hit && state != S_DODGE && !(state == S_SHIELD && bus.grounded)) begin
      state_n = S_HIT;
      timer_n = (eff_stun == '0) ? STUN_W'(1) : eff_stun;
      x_vel_n = eff_kb_x;
      y_vel_n = eff_kb_y;
    end else if (state == S_HIT) begin
      if (timer <= STUN_W'(1)) begin
        state_n = S_MOVE;
        timer_n = '0;
      end else begin
        timer_n = timer - STUN_W'(1);
      end
    end else if (state == S_LEDGE) begin
      timer_n = '0;
      if (up_rise) begin
        state_n = S_MOVE;
        y_vel_n = JUMP_V;
      end else if (bus.btn_down) begin
        state_n = S_MOVE;
      end else begin
        x_vel_n = '0;
        y_vel_n = '0;
      end
    end else if (!bus.grounded && bus.near_ledge && ledge_ok &&
                 (y_vel[VEL_W-1] || y_vel == '0)) begin
      state_n    = S_LEDGE;
      timer_n    = '0;
      x_vel_n    = '0;
      y_vel_n    = '0;
      ledge_ok_n = 1'b0;
    end else if ((state == S_ATTACK || state == S_DODGE) && timer != '0) begin
      if (timer == STUN_W'(1)) begin
        state_n = S_MOVE;
        timer_n = '0;
      end else begin
        timer_n = timer - STUN_W'(1);
      end
    end else if (atk_rise && (state == S_MOVE || state == S_SHIELD)) begin
      state_n = S_ATTACK;
      timer_n = STUN_W'(ATK_TICKS);
      if (bus.grounded) x_vel_n = '0;
    end else if (bus.grounded && bus.btn_shield && lr_rise) begin
      state_n = S_DODGE;
      timer_n = STUN_W'(DODGE_TICKS);
      x_vel_n = bus.btn_right ? DODGE_V : -DODGE_V;
    end else if (bus.grounded && bus.btn_shield) begin
      state_n = S_SHIELD;
      timer_n = '0;
      x_vel_n = '0;
      y_vel_n = '0;
    end else begin
      state_n = S_MOVE;
      timer_n = '0;
      if (bus.btn_right && !bus.btn_left) begin
        x_vel_n  = WALK_V;
        facing_n = 1'b1;
      end else if (bus.btn_left && !bus.btn_right) begin
        x_vel_n  = -WALK_V;
        facing_n = 1'b0;
      end else begin
        x_vel_n = '0;
      end
      if (bus.grounded && up_rise) y_vel_n = JUMP_V;
    end

    // Gravity is skipped on any tick that starts or ends on the ledge, so a
    // ledge grab reads 0 and a ledge jump launches at full jump speed
    if (!bus.grounded) begin
      if (state_n != S_LEDGE && state != S_LEDGE) y_vel_n = fall(y_vel_n);
    end else begin
      if (y_vel_n[VEL_W-1]) y_vel_n = '0;
      ledge_ok_n = 1'b1;
    end

    case (state_n)
      S_MOVE:   anim_n = !bus.grounded ? A_AIR : (x_vel_n != '0) ? A_WALK : A_IDLE;
      S_ATTACK: anim_n = A_ATTACK;
      S_DODGE:  anim_n = A_DODGE;
      S_SHIELD: anim_n = A_SHIELD;
      S_LEDGE:  anim_n = A_LEDGE;
      S_HIT:    anim_n = A_HIT;
      default:  anim_n = A_IDLE;
    endcase
  end

  // State registers update only on frame ticks; hits between ticks are latched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_MOVE;
      timer      <= '0;
      x_vel      <= '0;
      y_vel      <= '0;
      facing     <= 1'b1;
      ledge_ok   <= 1'b1;
      anim       <= A_IDLE;
      pend_valid <= 1'b0;
      pend_stun  <= '0;
      pend_kb_x  <= '0;
      pend_kb_y  <= '0;
      prev_atk   <= 1'b0;
      prev_up    <= 1'b0;
      prev_lr    <= 1'b0;
    end else if (bus.tick) begin
      state      <= state_n;
      timer      <= timer_n;
      x_vel      <= x_vel_n;
      y_vel      <= y_vel_n;
      facing     <= facing_n;
      ledge_ok   <= ledge_ok_n;
      anim       <= anim_n;
      pend_valid <= 1'b0;
      prev_atk   <= bus.btn_atk;
      prev_up    <= bus.btn_up;
      prev_lr    <= bus.btn_left ^ bus.btn_right;
    end else if (bus.hit) begin
      pend_valid <= 1'b1;
      pend_stun  <= bus.hit_stun;
      pend_kb_x  <= bus.hit_kb_x;
      pend_kb_y  <= bus.hit_kb_y;
    end
  end

  assign bus.x_velocity        = x_vel;
  assign bus.y_velocity        = y_vel;
  assign bus.current_animation = anim;
  assign bus.facing            = facing;

endmodule

// File: tb/tb_player_state_ctrl.sv
// Directed testbench for player_state_ctrl with hand-computed expectations.
module tb_player_state_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   assertCount = 0;
  int   failCount   = 0;

  player_state_ctrl_if #(.VEL_W(8), .STUN_W(8)) bus ();

  player_state_ctrl #(.VEL_W(8), .STUN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Pulse one frame tick with the currently driven inputs; returns on a negedge
  task automatic applyStimulus();
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic applyTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // One-cycle hit pulse away from any tick
  task automatic pulseHit(input int stun, input int kx, input int ky);
    @(negedge clk);
    bus.hit      = 1'b1;
    bus.hit_stun = 8'(stun);
    bus.hit_kb_x = 8'(kx);
    bus.hit_kb_y = 8'(ky);
    @(negedge clk);
    bus.hit      = 1'b0;
    bus.hit_stun = '0;
    bus.hit_kb_x = '0;
    bus.hit_kb_y = '0;
  endtask

  task automatic clearInputs();
    bus.tick = 0; bus.grounded = 1; bus.near_ledge = 0; bus.hit = 0;
    bus.hit_stun = '0; bus.hit_kb_x = '0; bus.hit_kb_y = '0;
    bus.btn_atk = 0; bus.btn_up = 0; bus.btn_down = 0;
    bus.btn_left = 0; bus.btn_right = 0; bus.btn_shield = 0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    clearInputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkAll(input string tag, input int x, input int y, input int anim, input int face);
    checkOutput({tag, "_x"}, int'(bus.x_velocity), x);
    checkOutput({tag, "_y"}, int'(bus.y_velocity), y);
    checkOutput({tag, "_anim"}, int'(bus.current_animation), anim);
    checkOutput({tag, "_face"}, int'(bus.facing), face);
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkAll("reset", 0, 0, 0, 1);
    rst = 1'b0;

    // Walk left, then airborne attack keeps x; fall to the -10 floor
    bus.btn_left = 1;
    applyStimulus();
    checkAll("walk_left", -3, 0, 1, 0);
    bus.grounded = 0;
    bus.btn_atk  = 1;
    applyStimulus();
    checkAll("air_attack", -3, -1, 3, 0);
    applyTicks(10);
    checkAll("attack_t10", -3, -10, 3, 0);
    // Asynchronous reset in the middle of a cycle, timer at 10
    #2 rst = 1'b1;
    #1 checkAll("reset_mid_attack", 0, 0, 0, 1);
    resetDut();

    // Grounded jump, gravity ticks, floor, landing
    bus.btn_up = 1;
    applyStimulus();
    checkAll("jump", 0, 12, 0, 1);
    bus.grounded = 0;
    applyStimulus();
    checkAll("rise1", 0, 11, 2, 1);
    applyStimulus();
    checkOutput("rise2_y", int'(bus.y_velocity), 10);
    applyTicks(30);
    checkOutput("fall_floor_y", int'(bus.y_velocity), -10);
    bus.grounded = 1;
    applyStimulus();
    checkAll("land", 0, 0, 0, 1);

    // Latched hit: stun 3, knockback +5/+8, back to MOVE after 3 ticks
    resetDut();
    pulseHit(3, 5, 8);
    applyStimulus();
    checkAll("hit", 5, 8, 7, 1);
    bus.grounded = 0;
    applyStimulus();
    checkAll("hit_t1", 5, 7, 7, 1);
    applyStimulus();
    checkAll("hit_t2", 5, 6, 7, 1);
    applyStimulus();
    checkAll("hit_exit", 5, 5, 2, 1);

    // Hit on the same cycle as the tick is used immediately
    resetDut();
    @(negedge clk);
    bus.hit = 1; bus.hit_stun = 8'd2; bus.hit_kb_x = 8'd1; bus.hit_kb_y = 8'd2;
    bus.tick = 1;
    @(negedge clk);
    bus.hit = 0; bus.tick = 0;
    checkAll("hit_same_cycle", 1, 2, 7, 1);

    // Shield, dodge left with facing kept, hit ignored during dodge
    resetDut();
    bus.btn_shield = 1;
    applyStimulus();
    checkOutput("shield_anim", int'(bus.current_animation), 5);
    bus.btn_left = 1;
    applyStimulus();
    checkAll("dodge", -6, 0, 4, 1);
    pulseHit(3, 5, 8);
    applyStimulus();
    checkAll("dodge_hit_ignored", -6, 0, 4, 1);
    applyTicks(13);
    checkOutput("dodge_t14_anim", int'(bus.current_animation), 4);
    applyStimulus();
    checkOutput("dodge_exit_anim", int'(bus.current_animation), 1);
    applyStimulus();
    checkAll("shield_again", 0, 0, 5, 1);
    pulseHit(3, 5, 8);
    applyStimulus();
    checkAll("shield_hit_ignored", 0, 0, 5, 1);

    // Ledge grab, ledge jump, re-grab blocked until grounded
    resetDut();
    bus.grounded = 0;
    applyStimulus();
    checkAll("fall", 0, -1, 2, 1);
    bus.near_ledge = 1;
    applyStimulus();
    checkAll("ledge_grab", 0, 0, 6, 1);
    applyStimulus();
    checkAll("ledge_hold", 0, 0, 6, 1);
    bus.btn_up = 1;
    applyStimulus();
    checkAll("ledge_jump", 0, 12, 2, 1);
    applyTicks(13);
    checkAll("regrab_blocked", 0, -1, 2, 1);
    bus.grounded = 1;
    applyStimulus();
    checkAll("ledge_land", 0, 0, 0, 1);
    bus.grounded = 0;
    applyStimulus();
    checkOutput("regrab_anim", int'(bus.current_animation), 6);

    // Held attack button: one 20-tick attack, no retrigger
    resetDut();
    bus.btn_atk = 1;
    applyStimulus();
    checkOutput("atk_start_anim", int'(bus.current_animation), 3);
    applyTicks(19);
    checkOutput("atk_t19_anim", int'(bus.current_animation), 3);
    applyStimulus();
    checkOutput("atk_end_anim", int'(bus.current_animation), 0);
    applyStimulus();
    checkOutput("atk_no_retrigger_anim", int'(bus.current_animation), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
